// File: rtl/johnson_counter_param.sv
// johnson_counter_param
//   WIDTH-bit Johnson (twisted-ring) counter with 2*WIDTH states. It counts up or
//   down, loads a state by index, and corrects itself out of illegal states. It also
//   provides a binary index decode of Q and a terminal-count flag.
//   Optional build macro JOHNSON_DECODE_EN adds the DEC output, a registered one-hot
//   decode of the next index. When the macro is undefined, DEC and its register do
//   not exist.
module johnson_counter_param #(
    parameter  int WIDTH = 8,
    localparam int IW    = $clog2(2*WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             DIR,
    input  logic             LOAD,
    input  logic [IW-1:0]    LOAD_IDX,
    output logic [WIDTH-1:0] Q,
    output logic [IW-1:0]    IDX,
    output logic             TC,
    output logic             ERR
`ifdef JOHNSON_DECODE_EN
    ,
    output logic [2*WIDTH-1:0] DEC
`endif
);

    localparam int NSTATES = 2*WIDTH;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             err_r;
    logic             err_next;
    logic             q_legal;
    logic             load_ok;

    // A legal Johnson code has at most one boundary between adjacent bits.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (v[i] != v[i+1]) n++;
        end
        return (n <= 1);
    endfunction

    // Index from the population count. Codes with the top bit set occupy the
    // upper half of the sequence. Illegal codes decode to 0.
    function automatic logic [IW-1:0] index_of(input logic [WIDTH-1:0] v);
        int p;
        p = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) p++;
        end
        if (!is_legal(v))
            return '0;
        else if (v[WIDTH-1])
            return IW'(NSTATES - p);
        else
            return IW'(p);
    endfunction

    // Code for index k. For k up to WIDTH the low k bits are 1. Above WIDTH the
    // low (k-WIDTH) bits are 0 and the remaining bits are 1.
    function automatic logic [WIDTH-1:0] code_of(input logic [IW-1:0] k);
        logic [WIDTH-1:0] c;
        int ki;
        ki = int'(k);
        c  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ki <= WIDTH)
                c[i] = (i < ki);
            else
                c[i] = (i >= ki - WIDTH);
        end
        return c;
    endfunction

    assign q_legal = is_legal(q_r);
    assign load_ok = (int'(LOAD_IDX) < NSTATES);

    // Next-state selection. Priority is load, then illegal-state correction,
    // then count, then hold. Reset is applied in the register itself.
    always_comb begin
        q_next   = q_r;
        err_next = 1'b0;
        if (LOAD) begin
            if (load_ok)
                q_next = code_of(LOAD_IDX);
            else
                err_next = 1'b1;
        end else if (!q_legal) begin
            q_next   = '1;
            err_next = 1'b1;
        end else if (EN) begin
            if (DIR)
                q_next = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            else
                q_next = {~q_r[0], q_r[WIDTH-1:1]};
        end
    end

    // State and error-pulse registers. Synchronous reset goes to all ones (index WIDTH).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_r   <= '1;
            err_r <= 1'b0;
        end else begin
            q_r   <= q_next;
            err_r <= err_next;
        end
    end

    // Combinational index decode and terminal count for the current direction.
    always_comb begin
        IDX = index_of(q_r);
        TC  = q_legal && (DIR ? (IDX == IW'(NSTATES-1)) : (IDX == '0));
    end

    assign Q   = q_r;
    assign ERR = err_r;

`ifdef JOHNSON_DECODE_EN
    logic [2*WIDTH-1:0] dec_r;
    logic [2*WIDTH-1:0] dec_next;

    // One-hot of the index that Q takes on this edge. All zeros when that state is illegal.
    always_comb begin
        dec_next = '0;
        if (is_legal(q_next))
            dec_next[index_of(q_next)] = 1'b1;
    end

    // Decode register, kept in step with Q.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dec_r        <= '0;
            dec_r[WIDTH] <= 1'b1;
        end else begin
            dec_r <= dec_next;
        end
    end

    assign DEC = dec_r;
`endif

endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param
//   Directed and random checks of johnson_counter_param (WIDTH=8, plus a WIDTH=6
//   instance for out-of-range loads) against an index-based reference model.
module tb_johnson_counter_param;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int W6 = 6;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RESET, EN, DIR, LOAD;
    logic [IW-1:0] LOAD_IDX;
    logic [W-1:0]  Q;
    logic [IW-1:0] IDX;
    logic          TC, ERR;

    logic          rst6, en6, dir6, ld6;
    logic [IW-1:0] ldi6;
    logic [W6-1:0] q6;
    logic [IW-1:0] idx6;
    logic          tc6, err6;

`ifdef JOHNSON_DECODE_EN
    logic [2*W-1:0]  DEC;
    logic [2*W6-1:0] dec6;
`endif

    johnson_counter_param #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .DIR(DIR), .LOAD(LOAD),
        .LOAD_IDX(LOAD_IDX), .Q(Q), .IDX(IDX), .TC(TC), .ERR(ERR)
`ifdef JOHNSON_DECODE_EN
        , .DEC(DEC)
`endif
    );

    johnson_counter_param #(.WIDTH(W6)) dut6 (
        .CLK(CLK), .RESET(rst6), .EN(en6), .DIR(dir6), .LOAD(ld6),
        .LOAD_IDX(ldi6), .Q(q6), .IDX(idx6), .TC(tc6), .ERR(err6)
`ifdef JOHNSON_DECODE_EN
        , .DEC(dec6)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mk;
    logic merr;

    // Johnson code for index k in a w-bit ring, computed with plain arithmetic.
    function automatic logic [31:0] code_of(input int w, input int k);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        if (k <= w) return (32'd1 << k) - 32'd1;
        else        return (~((32'd1 << (k - w)) - 32'd1)) & m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int k, input logic e_err);
        check({tag, "_q"},   32'(Q),   code_of(W, k));
        check({tag, "_idx"}, 32'(IDX), 32'(k));
        check({tag, "_tc"},  32'(TC),  32'(DIR ? (k == 2*W-1) : (k == 0)));
        check({tag, "_err"}, 32'(ERR), 32'(e_err));
`ifdef JOHNSON_DECODE_EN
        check({tag, "_dec"}, 32'(DEC), 32'd1 << k);
`endif
    endtask

    // One clock of the WIDTH=8 DUT: drive on the falling edge, advance the model, sample after the rising edge.
    task automatic step(input string tag, input logic rst, input logic en, input logic dir,
                        input logic ld, input int ldi);
        @(negedge CLK);
        RESET = rst; EN = en; DIR = dir; LOAD = ld; LOAD_IDX = IW'(ldi);
        @(posedge CLK);
        #1;
        merr = 1'b0;
        if (rst)     mk = W;
        else if (ld) mk = ldi;
        else if (en) mk = dir ? (mk + 1) % (2*W) : (mk + 2*W - 1) % (2*W);
        check_all(tag, mk, merr);
    endtask

    logic [7:0] up_tab [16] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                                8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [7:0] dn_tab [9]  = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};

    initial begin
        RESET = 1'b0; EN = 1'b0; DIR = 1'b1; LOAD = 1'b0; LOAD_IDX = '0;
        rst6 = 1'b1; en6 = 1'b0; dir6 = 1'b1; ld6 = 1'b0; ldi6 = '0;
        mk = W; merr = 1'b0;

        // Reset, then hold with EN low
        step("reset", 1, 0, 1, 0, 0);
        check("reset_q_lit", 32'(Q), 32'hFF);
        for (int i = 0; i < 10; i++) step("hold", 0, 0, 1, 0, 0);

        // Count up through the full sequence
        for (int i = 0; i < 16; i++) begin
            step("up", 0, 1, 1, 0, 0);
            check("up_lit", 32'(Q), 32'(up_tab[i]));
            check("up_tc_lit", 32'(TC), 32'(i == 6));
        end

        // Count down from all ones, through the wrap at index 0
        step("reset2", 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step("down", 0, 1, 0, 0, 0);
            check("down_lit", 32'(Q), 32'(dn_tab[i]));
            check("down_tc_lit", 32'(TC), 32'(i == 7));
        end

        // Direction flip at 1F
        step("ld5", 0, 0, 0, 1, 5);
        check("ld5_lit", 32'(Q), 32'h1F);
        step("flip", 0, 1, 1, 0, 0);
        check("flip_lit", 32'(Q), 32'h3F);

        // Load takes priority over EN
        step("ld12", 0, 1, 1, 1, 12);
        check("ld12_lit", 32'(Q), 32'hF0);
        step("ld3", 0, 1, 0, 1, 3);
        check("ld3_lit", 32'(Q), 32'h07);

        // WIDTH=6: an out-of-range load holds Q and pulses ERR for one cycle
        @(negedge CLK);
        EN = 1'b0; LOAD = 1'b0; RESET = 1'b0;
        rst6 = 1'b0; ld6 = 1'b1; ldi6 = 4'd4;
        @(posedge CLK); #1;
        check("w6_ld4_q", 32'(q6), 32'h0F);
        check("w6_ld4_err", 32'(err6), 32'd0);
        @(negedge CLK);
        ld6 = 1'b1; ldi6 = 4'd13; en6 = 1'b1;
        @(posedge CLK); #1;
        check("w6_bad_q", 32'(q6), 32'h0F);
        check("w6_bad_err", 32'(err6), 32'd1);
        @(negedge CLK);
        ld6 = 1'b0; en6 = 1'b0;
        @(posedge CLK); #1;
        check("w6_after_q", 32'(q6), 32'h0F);
        check("w6_after_err", 32'(err6), 32'd0);
        check("w6_after_idx", 32'(idx6), 32'd4);
        check("w8_idle_q", 32'(Q), code_of(W, mk));

        // Illegal-state upset: corrected to all ones on the next edge, even with EN high
        @(negedge CLK);
        RESET = 1'b0; LOAD = 1'b0; EN = 1'b1; DIR = 1'b1;
        force dut.q_r = 8'h5A;
        #1;
        check("illegal_idx", 32'(IDX), 32'd0);
        check("illegal_tc", 32'(TC), 32'd0);
        release dut.q_r;
        @(posedge CLK); #1;
        mk = W;
        check_all("fix", mk, 1'b1);
        step("fix_after", 0, 0, 1, 0, 0);

        // Reset wins over a simultaneous load
        step("rst_ld", 1, 1, 0, 1, 3);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
